// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: shares one single-port register file between a host port (0) and a decoder port (1).
// Round-robin by default; define REGARB_FIXED_PRIO_EN to give port 0 fixed priority.
module regfile_access_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [ADDR-1:0]  ADDR0,
  input  logic [ADDR-1:0]  ADDR1,
  input  logic [WIDTH-1:0] WDATA0,
  input  logic [WIDTH-1:0] WDATA1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             RVLD0,
  output logic             RVLD1,
  output logic [WIDTH-1:0] RDATA,
  output logic             RF_WrEn,
  output logic             RF_RdEn,
  output logic [ADDR-1:0]  RF_Address,
  output logic [WIDTH-1:0] RF_WrData,
  input  logic [WIDTH-1:0] RF_RdData
);
  logic win0, gnt, we, t0_v, t0_id, t1_v, t1_id;
`ifdef REGARB_FIXED_PRIO_EN
  assign win0 = REQ0;
`else
  logic ptr;
  assign win0 = REQ0 & (~REQ1 | ~ptr);
  // serving the preferred port hands preference to the other one
  always_ff @(posedge CLK or negedge RST)
    if (!RST) ptr <= 1'b0;
    else if ((GNT0 & ~ptr) | (GNT1 & ptr)) ptr <= ~ptr;
`endif
  assign GNT0  = RST & win0;
  assign GNT1  = RST & REQ1 & ~win0;
  assign gnt   = GNT0 | GNT1;
  assign we    = GNT1 ? WE1 : WE0;
  assign RDATA = RF_RdData;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      t0_v       <= 1'b0;
      t0_id      <= 1'b0;
      t1_v       <= 1'b0;
      t1_id      <= 1'b0;
      RVLD0      <= 1'b0;
      RVLD1      <= 1'b0;
    end else begin
      RF_WrEn <= gnt & we;
      RF_RdEn <= gnt & ~we;
      if (gnt) begin
        RF_Address <= GNT1 ? ADDR1 : ADDR0;
        RF_WrData  <= GNT1 ? WDATA1 : WDATA0;
      end
      t0_v  <= gnt & ~we;
      t0_id <= GNT1;
      t1_v  <= t0_v;
      t1_id <= t0_id;
      RVLD0 <= t1_v & ~t1_id;
      RVLD1 <= t1_v & t1_id;
    end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: directed and random traffic against a transaction-level model of the arbiter.
module tb_regfile_access_arbiter;
  localparam int W = 8, D = 64, A = 6;
  logic CLK = 0, RST = 0;
  logic REQ0 = 0, REQ1 = 0, WE0 = 0, WE1 = 0;
  logic [A-1:0] ADDR0 = '0, ADDR1 = '0;
  logic [W-1:0] WDATA0 = '0, WDATA1 = '0;
  logic GNT0, GNT1, RVLD0, RVLD1, RF_WrEn, RF_RdEn;
  logic [W-1:0] RDATA, RF_WrData, RF_RdData;
  logic [A-1:0] RF_Address;

  regfile_access_arbiter #(.WIDTH(W), .DEPTH(D), .ADDR(A)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVLD0(RVLD0), .RVLD1(RVLD1), .RDATA(RDATA),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData));

  always #5 CLK = ~CLK;

  // register file: write at the edge after the command, read sampled then, data one edge later
  logic [W-1:0] mem [D];
  logic rd_q;
  logic [A-1:0] ra_q;
  always @(posedge CLK or negedge RST)
    if (!RST) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
      rd_q <= 1'b0;
      ra_q <= '0;
      RF_RdData <= '0;
    end else begin
      if (RF_WrEn) mem[RF_Address] <= RF_WrData;
      rd_q <= RF_RdEn;
      ra_q <= RF_Address;
      if (rd_q) RF_RdData <= mem[ra_q];
    end

  typedef struct {int due; bit port; logic [W-1:0] data;} ret_t;
  ret_t rq[$];
  logic [W-1:0] shadow [D];
  bit pref1;
  logic e_we, e_re;
  logic [A-1:0] e_addr;
  logic [W-1:0] e_wd;
  int checks = 0, errors = 0, cyc = 0;
  bit g0, g1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    pref1 = 0;
    for (int i = 0; i < D; i++) shadow[i] = '0;
    e_we = 0; e_re = 0; e_addr = '0; e_wd = '0;
  endtask

  // called at a negedge with RST already asserted for at least a moment
  task automatic reset_dut();
    RST = 0;
    #1;
    model_reset();
    check("rst_gnt", 32'({GNT0, GNT1}), 32'(0));
    check("rst_rf", 32'({RF_WrEn, RF_RdEn, RF_Address, RF_WrData}), 32'(0));
    check("rst_rvld", 32'({RVLD0, RVLD1}), 32'(0));
    @(posedge CLK); cyc++;
    @(negedge CLK);
    RST = 1;
  endtask

  // one clock cycle: inputs are set by the caller at a negedge
  task automatic tick(output bit og0, output bit og1);
    bit e0, e1, p, w;
    logic [W-1:0] ed;
    logic [A-1:0] a;
    ret_t r;
    e0 = 0; e1 = 0; ed = '0;
    #1;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      e0 = !r.port; e1 = r.port; ed = r.data;
    end
    check("rvld0", 32'(RVLD0), 32'(e0));
    check("rvld1", 32'(RVLD1), 32'(e1));
    if (e0 || e1) check("rdata", 32'(RDATA), 32'(ed));
    check("rf_en", 32'({RF_WrEn, RF_RdEn}), 32'({e_we, e_re}));
    check("rf_addr", 32'(RF_Address), 32'(e_addr));
    check("rf_wdata", 32'(RF_WrData), 32'(e_wd));
    check("excl", 32'(RF_WrEn & RF_RdEn), 32'(0));
`ifdef REGARB_FIXED_PRIO_EN
    og0 = REQ0;
`else
    og0 = REQ0 && (!REQ1 || !pref1);
`endif
    og1 = REQ1 && !og0;
    check("gnt0", 32'(GNT0), 32'(og0));
    check("gnt1", 32'(GNT1), 32'(og1));
    e_we = 0; e_re = 0;
    if (og0 || og1) begin
      p = og1;
      w = p ? WE1 : WE0;
      a = p ? ADDR1 : ADDR0;
      e_addr = a;
      e_wd = p ? WDATA1 : WDATA0;
      e_we = w; e_re = !w;
      if (w) shadow[a] = e_wd;
      else rq.push_back('{cyc + 3, p, shadow[a]});
      if (p == pref1) pref1 = !pref1;
    end
    @(posedge CLK); cyc++;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    REQ0 = 0; REQ1 = 0;
    for (int i = 0; i < n; i++) tick(g0, g1);
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    reset_dut();
    // host write then read back
    REQ0 = 1; WE0 = 1; ADDR0 = 6'h05; WDATA0 = 8'hA5; tick(g0, g1);
    WE0 = 0; tick(g0, g1);
    idle(4);
    // contention from reset alternates
    reset_dut();
    REQ0 = 1; WE0 = 0; ADDR0 = 6'h01; REQ1 = 1; WE1 = 0; ADDR1 = 6'h02;
    for (int i = 0; i < 4; i++) tick(g0, g1);
    idle(4);
    // read-after-write across ports
    REQ1 = 1; WE1 = 1; ADDR1 = 6'h3F; WDATA1 = 8'h7E; tick(g0, g1);
    REQ1 = 0; REQ0 = 1; WE0 = 0; ADDR0 = 6'h3F; tick(g0, g1);
    idle(4);
    // streaming reads
    for (int i = 0; i < 8; i++) begin
      REQ0 = 1; WE0 = 0; ADDR0 = 6'(i); tick(g0, g1);
    end
    idle(4);
    // reset with a read in flight drops it and restores port-0 preference
    REQ1 = 1; WE1 = 0; ADDR1 = 6'h3F; tick(g0, g1);
    REQ1 = 0;
    reset_dut();
    idle(4);
    REQ0 = 1; WE0 = 0; ADDR0 = 6'h00; REQ1 = 1; WE1 = 0; ADDR1 = 6'h01;
    tick(g0, g1);
    idle(4);
    // random traffic, requests held until granted
    g0 = 0; g1 = 0;
    for (int n = 0; n < 600; n++) begin
      if (g0) REQ0 = 0;
      if (g1) REQ1 = 0;
      if (!REQ0 && $urandom_range(3) != 0) begin
        REQ0 = 1; WE0 = 1'($urandom_range(1));
        ADDR0 = 6'($urandom_range(7)); WDATA0 = 8'($urandom);
      end
      if (!REQ1 && $urandom_range(3) != 0) begin
        REQ1 = 1; WE1 = 1'($urandom_range(1));
        ADDR1 = ($urandom_range(3) == 0) ? 6'($urandom) : 6'($urandom_range(7));
        WDATA1 = 8'($urandom);
      end
      if (n == 300) reset_dut();
      tick(g0, g1);
    end
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
